// File: rtl/memory_access_stage.sv
// memory_access_stage
// -------------------
// RV64 memory stage placed directly after execute. Loads and stores go out over
// a valid/ready data-memory port. Load data is aligned to bit 0 and sign- or
// zero-extended to 64 bits. Non-memory instructions pass straight through to
// writeback one cycle later.
//
// Ports
//   clk, reset          clock; synchronous active-high reset
//   mem_enable          execute result valid (only sampled while idle)
//   alu_result          effective address, or writeback value for non-memory ops
//   store_data          rs2 contents
//   is_load, is_store   memory operation kind
//   funct3              access size/sign (B, H, W, D, BU, HU, WU)
//   rd_in, reg_write_in destination register and its write enable
//   dmem_req_*          request channel (valid/ready, 8-byte-aligned address,
//                       write enable, lane-shifted write data, byte strobes)
//   dmem_resp_*         response channel (load data or store acknowledgement)
//   wb_*                one-cycle writeback packet for the register file
//   busy                stage is occupied; upstream must hold
//   misaligned_fault    pulses with wb_valid for misaligned or illegal accesses

module memory_access_stage #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_enable,
  input  logic [63:0]       alu_result,
  input  logic [DATA_W-1:0] store_data,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [2:0]        funct3,
  input  logic [4:0]        rd_in,
  input  logic              reg_write_in,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic              dmem_we,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [7:0]        dmem_wstrb,
  input  logic              dmem_resp_valid,
  input  logic [DATA_W-1:0] dmem_resp_data,
  output logic              wb_valid,
  output logic [DATA_W-1:0] wb_data,
  output logic [4:0]        wb_rd,
  output logic              wb_reg_write,
  output logic              busy,
  output logic              misaligned_fault
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state, next_state;

  logic              accept;
  logic              is_mem;
  logic              aligned;
  logic              issue_req;
  logic [2:0]        lane;
  logic [7:0]        store_strb;
  logic [DATA_W-1:0] store_shifted;

  logic [2:0]        funct3_q;
  logic [2:0]        lane_q;
  logic [4:0]        rd_q;
  logic              reg_write_q;
  logic              is_store_q;

  logic [DATA_W-1:0] load_shifted;
  logic [DATA_W-1:0] load_value;

  assign accept    = (state == IDLE) && mem_enable;
  assign is_mem    = is_load | is_store;
  assign issue_req = accept && is_mem && aligned;
  assign lane      = alu_result[2:0];

  // Natural-alignment check on the incoming address. funct3=111 is not a legal
  // access size, so it is reported as misaligned and never reaches memory.
  always_comb begin
    aligned = 1'b0;
    case (funct3)
      3'b000, 3'b100: aligned = 1'b1;
      3'b001, 3'b101: aligned = (alu_result[0] == 1'b0);
      3'b010, 3'b110: aligned = (alu_result[1:0] == 2'b00);
      3'b011:         aligned = (alu_result[2:0] == 3'b000);
      default:        aligned = 1'b0;
    endcase
  end

  // Store encoding: the low two funct3 bits give the access size. Because the
  // access is already known to be aligned, the shifted strobe never spills
  // past lane 7.
  always_comb begin
    store_strb = 8'h00;
    case (funct3[1:0])
      2'b00:   store_strb = 8'b0000_0001 << lane;
      2'b01:   store_strb = 8'b0000_0011 << lane;
      2'b10:   store_strb = 8'b0000_1111 << lane;
      default: store_strb = 8'hFF;
    endcase
  end

  assign store_shifted = store_data << {lane, 3'b000};

  // Load extraction: move the addressed bytes down to bit 0, then extend
  // them according to the latched size/sign code.
  assign load_shifted = dmem_resp_data >> {lane_q, 3'b000};

  always_comb begin
    load_value = load_shifted;
    case (funct3_q)
      3'b000:  load_value = {{(DATA_W-8){load_shifted[7]}},   load_shifted[7:0]};
      3'b001:  load_value = {{(DATA_W-16){load_shifted[15]}}, load_shifted[15:0]};
      3'b010:  load_value = {{(DATA_W-32){load_shifted[31]}}, load_shifted[31:0]};
      3'b100:  load_value = {{(DATA_W-8){1'b0}},  load_shifted[7:0]};
      3'b101:  load_value = {{(DATA_W-16){1'b0}}, load_shifted[15:0]};
      3'b110:  load_value = {{(DATA_W-32){1'b0}}, load_shifted[31:0]};
      default: load_value = load_shifted;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and state-decoded outputs. A response arriving in the
  // same cycle as the request handshake is deliberately not looked at: the
  // response is only sampled in RESP.
  always_comb begin
    next_state     = state;
    dmem_req_valid = 1'b0;
    wb_valid       = 1'b0;
    busy           = (state != IDLE);
    case (state)
      IDLE: begin
        if (mem_enable) begin
          next_state = (is_mem && aligned) ? REQ : DONE;
        end
      end
      REQ: begin
        dmem_req_valid = 1'b1;
        if (dmem_req_ready) begin
          next_state = RESP;
        end
      end
      RESP: begin
        if (dmem_resp_valid) begin
          next_state = DONE;
        end
      end
      DONE: begin
        wb_valid   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Request payload is loaded once when the access is accepted and is held
  // untouched while REQ waits for ready, then cleared after the handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      dmem_addr  <= '0;
      dmem_we    <= 1'b0;
      dmem_wdata <= '0;
      dmem_wstrb <= 8'h00;
    end else if (issue_req) begin
      dmem_addr  <= {alu_result[ADDR_W-1:3], 3'b000};
      dmem_we    <= is_store;
      dmem_wdata <= is_store ? store_shifted : '0;
      dmem_wstrb <= is_store ? store_strb : 8'h00;
    end else if ((state == REQ) && dmem_req_ready) begin
      dmem_addr  <= '0;
      dmem_we    <= 1'b0;
      dmem_wdata <= '0;
      dmem_wstrb <= 8'h00;
    end
  end

  // Instruction context needed after the request has gone out.
  always_ff @(posedge clk) begin
    if (reset) begin
      funct3_q    <= 3'b000;
      lane_q      <= 3'b000;
      rd_q        <= 5'd0;
      reg_write_q <= 1'b0;
      is_store_q  <= 1'b0;
    end else if (accept) begin
      funct3_q    <= funct3;
      lane_q      <= lane;
      rd_q        <= rd_in;
      reg_write_q <= reg_write_in;
      is_store_q  <= is_store;
    end
  end

  // Writeback packet. It is formed on the cycle that enters DONE and cleared
  // when DONE is left, so these outputs read as zero outside the pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wb_data          <= '0;
      wb_rd            <= 5'd0;
      wb_reg_write     <= 1'b0;
      misaligned_fault <= 1'b0;
    end else if (accept && !is_mem) begin
      wb_data          <= alu_result[DATA_W-1:0];
      wb_rd            <= rd_in;
      wb_reg_write     <= reg_write_in;
      misaligned_fault <= 1'b0;
    end else if (accept && !aligned) begin
      wb_data          <= '0;
      wb_rd            <= rd_in;
      wb_reg_write     <= 1'b0;
      misaligned_fault <= 1'b1;
    end else if ((state == RESP) && dmem_resp_valid) begin
      wb_data          <= is_store_q ? '0 : load_value;
      wb_rd            <= rd_q;
      wb_reg_write     <= reg_write_q && !is_store_q;
      misaligned_fault <= 1'b0;
    end else if (state == DONE) begin
      wb_data          <= '0;
      wb_rd            <= 5'd0;
      wb_reg_write     <= 1'b0;
      misaligned_fault <= 1'b0;
    end
  end

endmodule

// File: tb/tb_memory_access_stage.sv
// Testbench for memory_access_stage. Directed instructions are issued from the
// main process; each pushes its expected writeback packet into a queue, and a
// separate monitor pops and compares whenever wb_valid is seen. The main
// process also plays the data memory and checks the request channel.

module tb_memory_access_stage;

  localparam logic [2:0] F_B  = 3'b000;
  localparam logic [2:0] F_H  = 3'b001;
  localparam logic [2:0] F_W  = 3'b010;
  localparam logic [2:0] F_D  = 3'b011;
  localparam logic [2:0] F_BU = 3'b100;
  localparam logic [2:0] F_HU = 3'b101;
  localparam logic [2:0] F_WU = 3'b110;
  localparam logic [2:0] F_XX = 3'b111;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_enable;
  logic [63:0] alu_result;
  logic [63:0] store_data;
  logic        is_load;
  logic        is_store;
  logic [2:0]  funct3;
  logic [4:0]  rd_in;
  logic        reg_write_in;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic [63:0] dmem_addr;
  logic        dmem_we;
  logic [63:0] dmem_wdata;
  logic [7:0]  dmem_wstrb;
  logic        dmem_resp_valid;
  logic [63:0] dmem_resp_data;
  logic        wb_valid;
  logic [63:0] wb_data;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic        busy;
  logic        misaligned_fault;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  rd;
    logic        rw;
    logic        fault;
  } wb_t;

  wb_t expq[$];

  always #5 clk = ~clk;

  memory_access_stage dut (
    .clk              (clk),
    .reset            (reset),
    .mem_enable       (mem_enable),
    .alu_result       (alu_result),
    .store_data       (store_data),
    .is_load          (is_load),
    .is_store         (is_store),
    .funct3           (funct3),
    .rd_in            (rd_in),
    .reg_write_in     (reg_write_in),
    .dmem_req_valid   (dmem_req_valid),
    .dmem_req_ready   (dmem_req_ready),
    .dmem_addr        (dmem_addr),
    .dmem_we          (dmem_we),
    .dmem_wdata       (dmem_wdata),
    .dmem_wstrb       (dmem_wstrb),
    .dmem_resp_valid  (dmem_resp_valid),
    .dmem_resp_data   (dmem_resp_data),
    .wb_valid         (wb_valid),
    .wb_data          (wb_data),
    .wb_rd            (wb_rd),
    .wb_reg_write     (wb_reg_write),
    .busy             (busy),
    .misaligned_fault (misaligned_fault)
  );

  // Single comparison point; automatic because the monitor and the main
  // process may call it in the same time step.
  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic pushExp(input logic [63:0] d, input logic [4:0] rd, input logic rw, input logic fault);
    wb_t e;
    e.data  = d;
    e.rd    = rd;
    e.rw    = rw;
    e.fault = fault;
    expq.push_back(e);
  endtask

  // Presents one instruction for a single cycle; returns at the following
  // negedge with mem_enable already dropped.
  task automatic applyStimulus(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] sdata,
                               input logic [4:0] rd, input logic rw);
    @(negedge clk);
    checkOutput("idle_before_issue", 64'(busy), 64'd0);
    mem_enable   = 1'b1;
    is_load      = ld;
    is_store     = st;
    funct3       = f3;
    alu_result   = addr;
    store_data   = sdata;
    rd_in        = rd;
    reg_write_in = rw;
    @(negedge clk);
    mem_enable = 1'b0;
    is_load    = 1'b0;
    is_store   = 1'b0;
  endtask

  // Data-memory model: holds ready low for 'delay' cycles while checking that
  // the request stays put, accepts it, then responds on the next cycle.
  task automatic serveMemory(input int delay, input logic [63:0] rdata,
                             input logic [63:0] exp_addr, input logic exp_we,
                             input logic [63:0] exp_wdata, input logic [7:0] exp_wstrb);
    int waited = 0;
    while (!dmem_req_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!dmem_req_valid) begin
      checkOutput("req_timeout", 64'(dmem_req_valid), 64'd1);
      return;
    end
    for (int i = 0; i <= delay; i++) begin
      checkOutput("req_valid", 64'(dmem_req_valid), 64'd1);
      checkOutput("req_addr", dmem_addr, exp_addr);
      checkOutput("req_we", 64'(dmem_we), 64'(exp_we));
      if (exp_we) begin
        checkOutput("req_wdata", dmem_wdata, exp_wdata);
        checkOutput("req_wstrb", 64'(dmem_wstrb), 64'(exp_wstrb));
      end
      if (i == delay) dmem_req_ready = 1'b1;
      @(negedge clk);
    end
    dmem_req_ready = 1'b0;
    mem_enable     = 1'b0;
    checkOutput("resp_req_dropped", 64'(dmem_req_valid), 64'd0);
    checkOutput("resp_busy", 64'(busy), 64'd1);
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = rdata;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = 64'd0;
  endtask

  // Scoreboard monitor: every writeback pulse must match the oldest expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && wb_valid) begin
        if (expq.size() == 0) begin
          checkOutput("wb_unexpected", 64'(wb_valid), 64'd0);
        end else begin
          wb_t e;
          e = expq.pop_front();
          checkOutput("wb_data", wb_data, e.data);
          checkOutput("wb_rd", 64'(wb_rd), 64'(e.rd));
          checkOutput("wb_reg_write", 64'(wb_reg_write), 64'(e.rw));
          checkOutput("wb_fault", 64'(misaligned_fault), 64'(e.fault));
        end
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset           = 1'b1;
    mem_enable      = 1'b0;
    alu_result      = 64'd0;
    store_data      = 64'd0;
    is_load         = 1'b0;
    is_store        = 1'b0;
    funct3          = 3'b000;
    rd_in           = 5'd0;
    reg_write_in    = 1'b0;
    dmem_req_ready  = 1'b0;
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = 64'd0;

    repeat (2) @(negedge clk);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_req_valid", 64'(dmem_req_valid), 64'd0);
    checkOutput("rst_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rst_wb_data", wb_data, 64'd0);
    checkOutput("rst_fault", 64'(misaligned_fault), 64'd0);
    reset = 1'b0;

    // Reset while waiting for a response; a late response must be ignored.
    applyStimulus(1'b1, 1'b0, F_D, 64'h100, 64'd0, 5'd3, 1'b1);
    checkOutput("rmo_req_valid", 64'(dmem_req_valid), 64'd1);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    checkOutput("rmo_in_resp", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset           = 1'b0;
    dmem_resp_valid = 1'b1;
    dmem_resp_data  = 64'h5555_5555_5555_5555;
    @(negedge clk);
    dmem_resp_valid = 1'b0;
    dmem_resp_data  = 64'd0;
    checkOutput("rmo_busy", 64'(busy), 64'd0);
    checkOutput("rmo_wb_valid", 64'(wb_valid), 64'd0);
    checkOutput("rmo_req_valid0", 64'(dmem_req_valid), 64'd0);
    checkOutput("rmo_wb_data", wb_data, 64'd0);
    checkOutput("rmo_wb_rd", 64'(wb_rd), 64'd0);
    checkOutput("rmo_wb_rw", 64'(wb_reg_write), 64'd0);
    checkOutput("rmo_addr", dmem_addr, 64'd0);
    checkOutput("rmo_wstrb", 64'(dmem_wstrb), 64'd0);
    @(negedge clk);
    checkOutput("rmo_wb_valid_late", 64'(wb_valid), 64'd0);

    // Pass-through, one-cycle latency.
    pushExp(64'h1234, 5'd5, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, F_B, 64'h1234, 64'd0, 5'd5, 1'b1);
    checkOutput("pt_latency", 64'(wb_valid), 64'd1);
    pushExp(64'hFFFF_0000_0000_0001, 5'd0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, F_D, 64'hFFFF_0000_0000_0001, 64'd0, 5'd0, 1'b0);
    checkOutput("pt2_latency", 64'(wb_valid), 64'd1);

    // Byte loads from lane 3 holding 0x80.
    pushExp(64'hFFFF_FFFF_FFFF_FF80, 5'd7, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, F_B, 64'h1003, 64'd0, 5'd7, 1'b1);
    serveMemory(0, 64'h0000_0000_8000_0000, 64'h1000, 1'b0, 64'd0, 8'h00);
    pushExp(64'h80, 5'd8, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, F_BU, 64'h1003, 64'd0, 5'd8, 1'b1);
    serveMemory(0, 64'h0000_0000_8000_0000, 64'h1000, 1'b0, 64'd0, 8'h00);

    // Halfword store into lanes 6-7 with ready held off three cycles.
    pushExp(64'd0, 5'd9, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, F_H, 64'h2006, 64'hABCD, 5'd9, 1'b1);
    serveMemory(3, 64'd0, 64'h2000, 1'b1, 64'hABCD_0000_0000_0000, 8'hC0);

    // Misaligned word load: no request, fault on the next cycle.
    pushExp(64'd0, 5'd10, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, F_W, 64'h3002, 64'd0, 5'd10, 1'b1);
    checkOutput("mis_no_req", 64'(dmem_req_valid), 64'd0);
    checkOutput("mis_latency", 64'(wb_valid), 64'd1);

    // Word, halfword and doubleword loads.
    pushExp(64'hFFFF_FFFF_8765_4321, 5'd11, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, F_W, 64'h4004, 64'd0, 5'd11, 1'b1);
    serveMemory(1, 64'h8765_4321_0000_0000, 64'h4000, 1'b0, 64'd0, 8'h00);
    pushExp(64'h0000_0000_8765_4321, 5'd12, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, F_WU, 64'h4004, 64'd0, 5'd12, 1'b1);
    serveMemory(0, 64'h8765_4321_0000_0000, 64'h4000, 1'b0, 64'd0, 8'h00);
    pushExp(64'h7FFF, 5'd13, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, F_H, 64'h5002, 64'd0, 5'd13, 1'b1);
    serveMemory(0, 64'h0000_0000_7FFF_0000, 64'h5000, 1'b0, 64'd0, 8'h00);
    pushExp(64'h8001, 5'd14, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, F_HU, 64'h5006, 64'd0, 5'd14, 1'b1);
    serveMemory(0, 64'h8001_0000_0000_0000, 64'h5000, 1'b0, 64'd0, 8'h00);
    pushExp(64'hFFFF_FFFF_FFFF_8001, 5'd15, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, F_H, 64'h5006, 64'd0, 5'd15, 1'b1);
    serveMemory(0, 64'h8001_0000_0000_0000, 64'h5000, 1'b0, 64'd0, 8'h00);
    pushExp(64'hDEAD_BEEF_CAFE_F00D, 5'd16, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, F_D, 64'h6000, 64'd0, 5'd16, 1'b1);
    serveMemory(2, 64'hDEAD_BEEF_CAFE_F00D, 64'h6000, 1'b0, 64'd0, 8'h00);

    // Byte, word and doubleword stores.
    pushExp(64'd0, 5'd17, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, F_B, 64'h7005, 64'h11, 5'd17, 1'b1);
    serveMemory(0, 64'd0, 64'h7000, 1'b1, 64'h0000_1100_0000_0000, 8'h20);
    pushExp(64'd0, 5'd18, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, F_W, 64'h7004, 64'hFFFF_FFFF_1234_5678, 5'd18, 1'b1);
    serveMemory(1, 64'd0, 64'h7000, 1'b1, 64'h1234_5678_0000_0000, 8'hF0);
    pushExp(64'd0, 5'd19, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b1, F_D, 64'h7008, 64'h0102_0304_0506_0708, 5'd19, 1'b1);
    serveMemory(0, 64'd0, 64'h7008, 1'b1, 64'h0102_0304_0506_0708, 8'hFF);

    // Fault cases: misaligned doubleword store, illegal size, odd halfword.
    pushExp(64'd0, 5'd1, 1'b0, 1'b1);
    applyStimulus(1'b0, 1'b1, F_D, 64'h8004, 64'h55, 5'd1, 1'b1);
    checkOutput("mis_sd_no_req", 64'(dmem_req_valid), 64'd0);
    pushExp(64'd0, 5'd2, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, F_XX, 64'h9000, 64'd0, 5'd2, 1'b1);
    checkOutput("f111_no_req", 64'(dmem_req_valid), 64'd0);
    pushExp(64'd0, 5'd4, 1'b0, 1'b1);
    applyStimulus(1'b1, 1'b0, F_H, 64'h9001, 64'd0, 5'd4, 1'b1);
    checkOutput("mis_lh_no_req", 64'(dmem_req_valid), 64'd0);

    // mem_enable held high while busy must be ignored.
    pushExp(64'h1111_2222_3333_4444, 5'd20, 1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0, F_D, 64'hA000, 64'd0, 5'd20, 1'b1);
    mem_enable   = 1'b1;
    alu_result   = 64'hBAD;
    rd_in        = 5'd21;
    reg_write_in = 1'b1;
    checkOutput("b2b_busy", 64'(busy), 64'd1);
    serveMemory(2, 64'h1111_2222_3333_4444, 64'hA000, 1'b0, 64'd0, 8'h00);

    repeat (4) @(negedge clk);
    checkOutput("end_idle", 64'(busy), 64'd0);
    checkOutput("wb_pending", 64'(expq.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
Name: memory_access_stage

Overview:
RV64 memory stage that sits directly downstream of the execute stage. It consumes the ALU result (the effective address) and the rs2 data, and performs loads and stores over a valid/ready data-memory port. Returned data is aligned and sign- or zero-extended to 64 bits, and a writeback packet goes to the register-file stage. Non-memory instructions pass through with one cycle of latency.

Parameters:
ADDR_W, 64, effective-address width and dmem_addr width
DATA_W, 64, data-bus width; fixed at 64 (8 byte lanes)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
mem_enable  in  1  execute result valid this cycle; sampled only in IDLE
alu_result  in  64  effective address (load/store) or writeback value (others)
store_data  in  64  rs2 contents
is_load  in  1  instruction is a load
is_store  in  1  instruction is a store
funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
rd_in  in  5  destination register
reg_write_in  in  1  instruction writes rd
dmem_req_valid  out  1  memory request valid
dmem_req_ready  in  1  memory accepts request
dmem_addr  out  ADDR_W  8-byte-aligned address (alu_result & ~7)
dmem_we  out  1  1 = store
dmem_wdata  out  64  store data shifted into byte lanes
dmem_wstrb  out  8  byte-lane write enables
dmem_resp_valid  in  1  load data / store acknowledgement valid
dmem_resp_data  in  64  aligned 64-bit read data
wb_valid  out  1  writeback packet valid, one-cycle pulse
wb_data  out  64  value for rd
wb_rd  out  5  destination register
wb_reg_write  out  1  write enable for rd; 0 on stores and faults
busy  out  1  stage not in IDLE; upstream must hold
misaligned_fault  out  1  pulses with wb_valid when the access is misaligned

Behaviour:
- Reset value of every output register is 0. State returns to IDLE. Any outstanding request is dropped, and a dmem_resp_valid arriving after reset is ignored.
- FSM states are IDLE, REQ, RESP and DONE. busy = (state != IDLE).
- IDLE, with mem_enable=1 and is_load=is_store=0:
  - Capture the inputs and go to DONE.
  - In DONE, wb_valid=1, wb_data=alu_result, wb_reg_write=reg_write_in.
  - Latency is 1 cycle.
- IDLE, with mem_enable=1 and a memory op:
  - Latch address, store_data, funct3 and rd.
  - Alignment check: H needs addr[0]=0; W/WU needs addr[1:0]=0; D needs addr[2:0]=0. B is always aligned.
  - Misaligned: no request is issued; go to DONE with misaligned_fault=1, wb_reg_write=0, wb_data=0.
  - Aligned: go to REQ.
- REQ: dmem_req_valid=1. Address, we, wdata and wstrb stay stable until dmem_req_ready=1 in the same cycle; that handshake moves the FSM to RESP.
- RESP: wait for dmem_resp_valid, then go to DONE and form wb_data. dmem_req_valid=0.
- DONE: wb_valid=1 for exactly 1 cycle, then IDLE. mem_enable is accepted again the following cycle.
- mem_enable while busy=1 is ignored.
- Store encoding, with lane = addr[2:0]:
  - wstrb: B 8'b1<<lane; H 8'b11<<lane; W 8'hF<<lane; D 8'hFF.
  - wdata = store_data << (8*lane).
- Load extraction: shifted = resp_data >> (8*lane), then extend by size:
  - B / H / W: sign-extend bit 7 / 15 / 31.
  - BU / HU / WU: zero-extend.
  - D: take unchanged.
- A store completes on its response acknowledgement; wb_reg_write=0 and wb_data=0.
- Minimum latency for an aligned memory op is 3 cycles: REQ with immediate ready, one RESP cycle, then DONE.
- Case where req_ready and resp_valid are asserted in the same cycle while in REQ: resp_valid is ignored. The memory must respond no earlier than the cycle after the request handshake.
- funct3=111 with is_load or is_store is treated as misaligned (fault), with no request.

Test Plan:
- Reset mid-op: enter RESP, assert reset, then raise resp_valid the next cycle -> state IDLE, wb_valid never asserts, all outputs 0.
- Pass-through: alu_result=64'h1234, reg_write_in=1, rd_in=5 -> the next cycle gives wb_valid=1, wb_data=64'h1234, wb_rd=5.
- Load LB from addr 0x1003 with resp_data=64'h0000_0000_8000_0000:
  - dmem_addr=0x1000, shifted byte = 0x80, so wb_data=64'hFFFF_FFFF_FFFF_FF80.
  - The same access as LBU gives wb_data=64'h80.
- Store SH with addr 0x2006, store_data=64'hABCD, ready held low 3 cycles:
  - req_valid is held and stable for those cycles.
  - dmem_addr=0x2000, wstrb=8'hC0, wdata=64'hABCD_0000_0000_0000.
  - wb_reg_write=0.
- Misaligned LW at addr 0x3002 -> dmem_req_valid stays 0, and the next cycle gives wb_valid=1, misaligned_fault=1, wb_reg_write=0.
- Back-to-back: mem_enable pulsed while busy=1 -> the pulse is ignored; exactly one wb_valid results per accepted instruction.
